// File: rtl/spi_req_arbiter_pkg.sv
// Shared types and field widths for the SPI request arbiter and its bus interface.
package spi_arb_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int CSEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_XFER      = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

endpackage

// File: rtl/spi_req_arbiter_if.sv
// Requester-side and SPI-master-side signals of the arbiter, bundled as one interface.
interface spi_req_arbiter_if
  import spi_arb_pkg::*;
#(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ*CSEL_W-1:0] req_clk_sel;
  logic [NREQ-1:0]        req_cpol;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic [NREQ-1:0]        err;
  logic [DATA_W-1:0]      rdata;

  logic                   m_start_n;
  logic [ADDR_W-1:0]      m_addr;
  logic [DATA_W-1:0]      m_wdata;
  logic [CSEL_W-1:0]      m_clk_sel;
  logic                   m_cpol;
  logic                   m_busy;
  logic [DATA_W-1:0]      m_rdata;

  modport master (
    input  req, req_addr, req_wdata, req_clk_sel, req_cpol, m_busy, m_rdata,
    output gnt, done, err, rdata, m_start_n, m_addr, m_wdata, m_clk_sel, m_cpol
  );

  modport slave (
    output req, req_addr, req_wdata, req_clk_sel, req_cpol, m_busy, m_rdata,
    input  gnt, done, err, rdata, m_start_n, m_addr, m_wdata, m_clk_sel, m_cpol
  );

endinterface

// File: rtl/spi_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx,
  output logic            any
);

  logic [NREQ-1:0] rot;
  int              off;
  int              sum;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    rot = NREQ'({req, req} >> ptr);
    any = |req;
    off = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    sum = off + int'(ptr);
    if (sum >= NREQ) sum = sum - NREQ;
    win_idx = IW'(sum);
    win_oh  = any ? (NREQ'(1) << sum) : '0;
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one SPI byte master among NREQ requesters: round-robin grant, start/busy
// handshake with timeout, and a per-requester done or err pulse.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input logic              clk,
  input logic              rst,
  spi_req_arbiter_if.master bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

  state_t            state, state_d;
  logic [IW-1:0]     ptr, ptr_d, widx, widx_d;
  logic [NREQ-1:0]   gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              start_n_q, start_n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CSEL_W-1:0] csel_q, csel_d;
  logic              cpol_q, cpol_d;
  logic [TW-1:0]     cnt, cnt_d;
  logic              busy_p0, busy_s;

  logic [NREQ-1:0]   pick_oh;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    widx_d    = widx;
    gnt_d     = gnt_q;
    done_d    = '0;
    err_d     = '0;
    rdata_d   = rdata_q;
    start_n_d = start_n_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    csel_d    = csel_q;
    cpol_d    = cpol_q;
    cnt_d     = cnt;
    unique case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_d   = ST_WAIT_BUSY;
          widx_d    = pick_idx;
          gnt_d     = pick_oh;
          addr_d    = bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
          wdata_d   = bus.req_wdata[pick_idx*DATA_W +: DATA_W];
          csel_d    = bus.req_clk_sel[pick_idx*CSEL_W +: CSEL_W];
          cpol_d    = bus.req_cpol[pick_idx];
          start_n_d = 1'b0;
          cnt_d     = '0;
        end
      end
      // Start is a level: the master samples it on its slow SCK, so hold until busy is seen.
      ST_WAIT_BUSY: begin
        if (busy_s) begin
          start_n_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_XFER;
        end else if (cnt == TMO) begin
          start_n_d = 1'b1;
          err_d     = gnt_q;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_XFER: begin
        if (!busy_s) begin
          rdata_d = bus.m_rdata;
          done_d  = gnt_q;
          state_d = ST_DONE;
        end else if (cnt == TMO) begin
          err_d   = gnt_q;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_DONE: begin
        gnt_d     = '0;
        start_n_d = 1'b1;
        ptr_d     = (widx == IW'(NREQ - 1)) ? '0 : widx + 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      widx      <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
      start_n_q <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      csel_q    <= '0;
      cpol_q    <= 1'b0;
      cnt       <= '0;
      busy_p0   <= 1'b0;
      busy_s    <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      widx      <= widx_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      start_n_q <= start_n_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      csel_q    <= csel_d;
      cpol_q    <= cpol_d;
      cnt       <= cnt_d;
      busy_p0   <= bus.m_busy;
      busy_s    <= busy_p0;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.m_start_n = start_n_q;
  assign bus.m_addr    = addr_q;
  assign bus.m_wdata   = wdata_q;
  assign bus.m_clk_sel = csel_q;
  assign bus.m_cpol    = cpol_q;

endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
- Round-robin arbiter and transaction sequencer that shares one SPI byte master between NREQ requesters.
- Latches the winning requester's slave address, write byte, clock select and CPOL, and drives them to the master.
- Runs the master's start/busy handshake and returns the received byte with a per-requester done or error pulse.
- Sits between CPU-side/peripheral requesters and the SPI master, in the system clock domain.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 1023, max clk cycles allowed in WAIT_BUSY and, separately, in XFER.
- TW, 10, timeout counter width; TIMEOUT must be less than 2**TW.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  request level per requester; hold high until done/err.
- req_addr  in  NREQ*4  slave address per requester; slice i = [4i+3:4i].
- req_wdata  in  NREQ*8  byte to transmit per requester.
- req_clk_sel  in  NREQ*3  SCK divider select per requester.
- req_cpol  in  NREQ  clock polarity per requester.
- gnt  out  NREQ  one-hot; high while requester i owns the master.
- done  out  NREQ  one-cycle pulse: transfer for i finished, rdata valid.
- err  out  NREQ  one-cycle pulse: transfer for i timed out.
- rdata  out  8  last received byte; held until the next done.
- m_start_n  out  1  active-low start to the master.
- m_addr  out  4  registered copy of the winner's req_addr.
- m_wdata  out  8  registered copy of the winner's req_wdata.
- m_clk_sel  out  3  registered copy of the winner's req_clk_sel.
- m_cpol  out  1  registered copy of the winner's req_cpol.
- m_busy  in  1  master busy; asynchronous to clk (SCK domain).
- m_rdata  in  8  master receive byte; stable while m_busy is low.

Behaviour:
- Reset (rst=0, asynchronous), all outputs:
  - gnt=0, done=0, err=0, rdata=8'h00.
  - m_start_n=1, m_addr=0, m_wdata=0, m_clk_sel=0, m_cpol=0.
  - Priority pointer = 0, state = IDLE, busy synchronizer flops = 0.
- Busy synchronizer: m_busy passes through two flops to give busy_s. All decisions use busy_s only.
- States: IDLE, WAIT_BUSY, XFER, DONE. The encoding lives in the package.
- IDLE:
  - If req is non-zero, pick the first set bit scanning from ptr upward, wrapping modulo NREQ.
  - Next edge: gnt[w]=1, m_* fields loaded from slice w, m_start_n=0, timeout counter cleared, state=WAIT_BUSY.
  - Latency from req high in IDLE to gnt/m_start_n is 1 clk.
- WAIT_BUSY:
  - Hold m_start_n=0 until busy_s=1. The master samples start on slow SCK, so a pulse is not enough.
  - On busy_s=1: m_start_n=1, counter cleared, state=XFER.
  - If the counter reaches TIMEOUT first: state=DONE with error flagged.
- XFER:
  - On busy_s falling to 0: rdata<=m_rdata, state=DONE.
  - If the counter reaches TIMEOUT first: error flagged, rdata unchanged.
- DONE (exactly 1 cycle):
  - Pulse done[w], or err[w] if flagged.
  - gnt and m_start_n return to 0 and 1.
  - ptr <= (w+1) mod NREQ, then state=IDLE.
  - Minimum gap between grants is 1 IDLE cycle.
- Arbitration fairness: after requester w is served, w has lowest priority. A continuously requesting port waits at most NREQ-1 transfers.
- Simultaneous requests in IDLE: only the winner is granted. Others stay pending with no loss.
- Request dropped mid-transaction: the transfer still completes and done/err still pulses for that index. The m_* fields are never changed while gnt is non-zero.
- Request payload changes after grant: ignored, because the fields were registered at grant.
- busy_s already 1 on entry to WAIT_BUSY (stale master): treated as started. Next state XFER, no error.
- Timeout counter saturates at TIMEOUT and never wraps.
- Reset asserted mid-transfer: immediate return to reset values and m_start_n=1. The master is not otherwise aborted.

Decomposition:
- Package spi_arb_pkg holds:
  - state encoding localparams ST_IDLE, ST_WAIT_BUSY, ST_XFER, ST_DONE;
  - field widths ADDR_W=4, DATA_W=8, CSEL_W=3.
- One natural sub-module, rr_pick: combinational round-robin picker (req, ptr -> one-hot winner and index). It is reused by future shared-bus blocks.
- The synchronizer is inline (two flops).

Test Plan:
1. Reset, then req=4'b0100, req_addr slice2=4'h5, wdata=8'hA5. Master model raises busy 6 clk after start and drops it 40 clk later with m_rdata=8'h3C. Required: gnt=4'b0100 one clk after req, m_addr=5, m_wdata=A5, m_start_n low until busy_s seen, done[2] single pulse, rdata=8'h3C.
2. req=4'b1111 held continuously, ptr=0. Required: grant order 0,1,2,3,0; each done pulse matches its gnt index; never two gnt bits set.
3. Master model never raises busy, TIMEOUT=1023. Required: err[1] pulses 1024±2 clk after grant, done stays 0, rdata unchanged, m_start_n returns to 1, next request is served normally.
4. Requester 3 drops req and changes wdata 5 clk after grant. Required: m_wdata keeps the original value, done[3] still pulses, ptr advances to 0.
5. rst driven low in the middle of XFER. Required: all outputs at reset values in the same cycle (asynchronous), and after rst=1 arbitration restarts from index 0.
6. Busy held high by the model before the grant. Required: WAIT_BUSY exits within 3 clk to XFER, no err, and done arrives after busy drops.
